pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (ID/EX, EX/MEM, MEM/WB class).
- Carries an opaque payload plus an exception code between two pipeline stages using a valid/ready handshake and a 2-entry skid buffer.
- in_ready depends only on internal state, never combinationally on out_ready, which breaks the global stall path.
- Provides flush, NOP-bubble output and a saturating back-pressure cycle counter for performance monitoring.

Parameters:
- DATA_W, 128, payload width in bits.
- EXC_W, 5, exception-code width.
- EC_NONE, 0, exception code meaning "no exception".
- NOP_VALUE, 0, payload value presented when the stage is empty or flushed. Width DATA_W.
- CNT_W, 16, back-pressure counter width.

Ports:
- cpu_clk_75M  in  1  stage clock.
- cpu_rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream has a valid entry.
- in_ready  out  1  buffer can accept an entry this cycle.
- in_data  in  DATA_W  upstream payload.
- in_exc_code  in  EXC_W  upstream exception code.
- out_valid  out  1  downstream entry is valid.
- out_ready  in  1  downstream accepts the entry this cycle.
- out_data  out  DATA_W  head payload; NOP_VALUE when out_valid=0.
- out_exc_code  out  EXC_W  head exception code; EC_NONE when out_valid=0.
- exc_pending  out  1  out_valid && out_exc_code != EC_NONE.
- flush  in  1  synchronous discard of all entries.
- cnt_clr  in  1  synchronous clear of bp_cnt.
- bp_cnt  out  CNT_W  back-pressure cycle count.

Behaviour:
- Reset is asynchronous and active-high. Clock is cpu_clk_75M.
- Storage: main register {data, exc} and skid register {data, exc}.
- State: EMPTY, ONE (main full), TWO (main and skid full).
- in_ready = (state != TWO). out_valid = (state != EMPTY). Both decode from the state register only.
- out_data/out_exc_code: main register contents when out_valid=1, otherwise NOP_VALUE/EC_NONE.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- Transitions:
  - EMPTY: in_fire -> ONE, main <= in.
  - ONE, in_fire & out_fire -> ONE, main <= in.
  - ONE, in_fire & !out_fire -> TWO, skid <= in.
  - ONE, !in_fire & out_fire -> EMPTY, main <= NOP.
  - TWO: out_fire -> ONE, main <= skid, skid <= NOP. Otherwise hold. in_ready=0 in TWO, so there is no in_fire.
- Latency: 1 cycle from in_fire to out_valid. Throughput: 1 entry per cycle when out_ready is held at 1.
- Ordering is strictly FIFO. The skid entry never overtakes main.
- Flush:
  - Priority below reset, above everything else.
  - Next state EMPTY; main and skid <= NOP_VALUE/EC_NONE.
  - in_fire and out_fire in a flush cycle are ignored: nothing is captured or counted as transferred.
  - bp_cnt is unaffected by flush.
- bp_cnt:
  - Increments when out_valid & !out_ready & !flush.
  - Saturates at 2^CNT_W-1; no wrap.
  - cnt_clr has priority over increment and forces 0.
- Reset values: state EMPTY, in_ready=1, out_valid=0, out_data=NOP_VALUE, out_exc_code=EC_NONE, exc_pending=0, bp_cnt=0, skid=NOP.
- Reset asserted mid-transfer drops all entries immediately (asynchronous). The first in_fire can occur in the first clock edge after deassertion.
- Entries with an exception travel like normal entries. The block never generates or modifies exception codes.
- in_data is sampled only on in_fire. Payload changes while in_valid=0 have no effect.

Decomposition:
- Shared package/defines: EC_NONE, the exception-code width, the stage-state encoding (EMPTY=2'b00, ONE=2'b01, TWO=2'b10) and the default NOP payload.
- One natural sub-module: pipe_entry_reg, an enable-loaded {data, exc} register with synchronous clear-to-NOP. It is instantiated twice, for main and skid.
- Control FSM and counter stay in the top.

Test Plan:
- Reset then idle, DATA_W=128, NOP_VALUE=0 -> in_ready=1, out_valid=0, out_data=0, bp_cnt=0. Drive in_valid=1, in_data=0xA5 -> next cycle out_valid=1, out_data=0xA5.
- Streaming, out_ready=1 held, inputs 1,2,3,4 on consecutive cycles -> outputs 1,2,3,4 on consecutive cycles; in_ready stays 1; bp_cnt=0.
- Back-pressure: out_ready=0 while sending 0x10, 0x11 -> state TWO, in_ready=0, 0x12 held off. Release out_ready -> outputs 0x10, 0x11, 0x12 in order; bp_cnt equals the number of stalled valid cycles.
- Flush in state TWO with in_valid=1 (0x99) and out_ready=1 on the same cycle -> next cycle out_valid=0, in_ready=1, out_data=0; 0x99 is never output; bp_cnt is unchanged.
- Exception propagation: in_exc_code=0x04 with data 0x20 -> at the output, out_exc_code=0x04 and exc_pending=1. The following clean entry shows exc_pending=0.
- Counter saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> bp_cnt=15 and stays. Pulse cnt_clr together with a stall -> bp_cnt=0 that cycle.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// Shared defaults and stage-state encoding for the pipeline stage buffer.
package pipe_stage_buf_pkg;

  localparam int unsigned DATA_W_DEF = 128;
  localparam int unsigned EXC_W_DEF  = 5;
  localparam int unsigned CNT_W_DEF  = 16;

  localparam logic [EXC_W_DEF-1:0]  EC_NONE_DEF = '0;
  localparam logic [DATA_W_DEF-1:0] NOP_DEF     = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } stage_state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// {data, exc} register: load on ld_i, synchronous clear-to-NOP on clr_i (clear wins).
// Single-cycle update; no flow control of its own.
module pipe_entry_reg #(
  parameter int unsigned           DATA_W    = 128,
  parameter int unsigned           EXC_W     = 5,
  parameter logic [DATA_W-1:0]     NOP_VALUE = '0,
  parameter logic [EXC_W-1:0]      EC_NONE   = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [EXC_W-1:0]  exc_i,
  output logic [DATA_W-1:0] data_o,
  output logic [EXC_W-1:0]  exc_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [EXC_W-1:0]  exc_q,  exc_d;

  always_comb begin
    data_d = data_q;
    exc_d  = exc_q;
    if (clr_i) begin
      data_d = NOP_VALUE;
      exc_d  = EC_NONE;
    end else if (ld_i) begin
      data_d = data_i;
      exc_d  = exc_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= NOP_VALUE;
      exc_q  <= EC_NONE;
    end else begin
      data_q <= data_d;
      exc_q  <= exc_d;
    end
  end

  assign data_o = data_q;
  assign exc_o  = exc_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage buffer with 2-entry skid, 1-cycle latency, full throughput.
// in_ready decodes from state only, so downstream stalls never reach upstream combinationally.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter int unsigned       EXC_W     = EXC_W_DEF,
  parameter logic [EXC_W-1:0]  EC_NONE   = EXC_W'(EC_NONE_DEF),
  parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(NOP_DEF),
  parameter int unsigned       CNT_W     = CNT_W_DEF
) (
  input  logic              cpu_clk_75M,
  input  logic              cpu_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc_code,
  output logic              exc_pending,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bp_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stage_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_fire, out_fire;
  logic              main_ld, main_clr, main_from_skid, skid_ld, skid_clr;
  logic [DATA_W-1:0] main_data, skid_data, main_in_data;
  logic [EXC_W-1:0]  main_exc, skid_exc, main_in_exc;

  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_ld = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_ld = 1'b1;
          end else if (in_fire) begin
            state_d = ST_TWO;
            skid_ld = 1'b1;
          end else if (out_fire) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
          end
        end
        ST_TWO: begin
          // Skid drains into main so it can never overtake the head entry.
          if (out_fire) begin
            state_d        = ST_ONE;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_in_data = main_from_skid ? skid_data : in_data;
  assign main_in_exc  = main_from_skid ? skid_exc  : in_exc_code;

  pipe_entry_reg #(
    .DATA_W(DATA_W), .EXC_W(EXC_W), .NOP_VALUE(NOP_VALUE), .EC_NONE(EC_NONE)
  ) u_main (
    .clk_i(cpu_clk_75M), .rst_i(cpu_rst), .clr_i(main_clr), .ld_i(main_ld),
    .data_i(main_in_data), .exc_i(main_in_exc), .data_o(main_data), .exc_o(main_exc)
  );

  pipe_entry_reg #(
    .DATA_W(DATA_W), .EXC_W(EXC_W), .NOP_VALUE(NOP_VALUE), .EC_NONE(EC_NONE)
  ) u_skid (
    .clk_i(cpu_clk_75M), .rst_i(cpu_rst), .clr_i(skid_clr), .ld_i(skid_ld),
    .data_i(in_data), .exc_i(in_exc_code), .data_o(skid_data), .exc_o(skid_exc)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_valid && !out_ready && !flush && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge cpu_clk_75M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data     = out_valid ? main_data : NOP_VALUE;
  assign out_exc_code = out_valid ? main_exc  : EC_NONE;
  assign exc_pending  = out_valid && (main_exc != EC_NONE);
  assign bp_cnt       = cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomised and directed bench for pipe_stage_buf against a 2-deep queue reference model.
module tb_pipe_stage_buf;

  localparam int DW = 128;
  localparam int EW = 5;
  localparam int CW = 4;
  localparam int CNT_SAT = (1 << CW) - 1;

  typedef struct {
    logic [DW-1:0] d;
    logic [EW-1:0] e;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [EW-1:0] in_exc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [EW-1:0] out_exc;
  logic          exc_pending;
  logic          flush = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] bp_cnt;

  int checks = 0;
  int failures = 0;

  ent_t model_q[$];
  int   model_cnt = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DW), .EXC_W(EW), .CNT_W(CW)) dut (
    .cpu_clk_75M(clk), .cpu_rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_exc_code(in_exc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_exc_code(out_exc), .exc_pending(exc_pending),
    .flush(flush), .cnt_clr(cnt_clr), .bp_cnt(bp_cnt)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare against the model, then advance the model with the inputs
  // that the coming rising edge will see.
  always @(negedge clk) begin
    ent_t          head;
    logic          acc, pop;
    logic [DW-1:0] exp_d;
    logic [EW-1:0] exp_e;
    if (rst) begin
      model_q.delete();
      model_cnt = 0;
    end
    exp_d = '0;
    exp_e = '0;
    if (model_q.size() > 0) begin
      head  = model_q[0];
      exp_d = head.d;
      exp_e = head.e;
    end
    chk("in_ready",    in_ready,    model_q.size() < 2);
    chk("out_valid",   out_valid,   model_q.size() > 0);
    chk("out_data",    out_data,    exp_d);
    chk("out_exc",     out_exc,     exp_e);
    chk("exc_pending", exc_pending, (model_q.size() > 0) && (exp_e != '0));
    chk("bp_cnt",      bp_cnt,      model_cnt);
    if (!rst) begin
      acc = in_valid && (model_q.size() < 2) && !flush;
      pop = (model_q.size() > 0) && out_ready && !flush;
      if (cnt_clr) model_cnt = 0;
      else if ((model_q.size() > 0) && !out_ready && !flush && model_cnt < CNT_SAT) model_cnt++;
      if (flush) model_q.delete();
      if (pop) void'(model_q.pop_front());
      if (acc) model_q.push_back('{d: in_data, e: in_exc});
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [EW-1:0] e);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_exc   = e;
    for (int i = 0; i < 64; i++) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) begin
      failures++;
      $display("FAIL send_timeout data=%0h never accepted", d);
    end
    in_valid = 1'b0;
    in_data  = DW'($urandom);
  endtask

  initial begin
    logic [DW-1:0] rd;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    // Single entry, then streaming with out_ready held high.
    out_ready = 1'b1;
    send(128'hA5, 5'd0);
    cyc(1);
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = DW'(i);
      cyc(1);
    end
    in_valid = 1'b0;
    cyc(3);

    // Back-pressure: fill to two entries, third waits.
    out_ready = 1'b0;
    send(128'h10, 5'd0);
    send(128'h11, 5'd0);
    in_valid = 1'b1;
    in_data  = 128'h12;
    cyc(4);
    out_ready = 1'b1;
    send(128'h12, 5'd0);
    cyc(4);

    // Flush while full, with a competing input and output in the same cycle.
    out_ready = 1'b0;
    send(128'h30, 5'd0);
    send(128'h31, 5'd0);
    cyc(1);
    in_valid  = 1'b1;
    in_data   = 128'h99;
    out_ready = 1'b1;
    flush     = 1'b1;
    cyc(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    cyc(2);

    // Exception code travels with its entry.
    send(128'h20, 5'h04);
    send(128'h21, 5'h00);
    cyc(3);

    // Counter saturation, then clear during a stall.
    out_ready = 1'b0;
    send(128'h40, 5'd0);
    cyc(20);
    cnt_clr = 1'b1;
    cyc(1);
    cnt_clr = 1'b0;
    cyc(3);
    out_ready = 1'b1;
    cyc(2);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rd;
      in_exc    = ($urandom_range(0, 3) == 0) ? EW'($urandom_range(1, 31)) : '0;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      cnt_clr   = ($urandom_range(0, 63) == 0);
      if (i == 300) begin
        #2 rst = 1'b1;
        cyc(2);
        rst = 1'b0;
      end else begin
        cyc(1);
      end
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    cnt_clr   = 1'b0;
    out_ready = 1'b1;
    cyc(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
